// File: rtl/at_seq_ctrl.sv
// at_seq_ctrl: issue/writeback sequencer for the AlphaTensor 4x4 mod-2 matrix-multiply datapath.
// Optional define AT_SEQ_HAZARD_CHECK_EN adds a RAW/WAW pending-address scoreboard.
module at_seq_ctrl #(
  parameter  int unsigned ADDR_W       = 4,
  parameter  int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rs1,
  output logic [ADDR_W-1:0] mem_rs2,
  output logic              pipe_vld,
  output logic [ADDR_W-1:0] pipe_rd,
  input  logic              wb_vld,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  input  logic              drain_req,
  output logic              drain_done,
  output logic              busy,
  output logic [CNT_W-1:0]  inflight_cnt,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               r_err;
  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_rs1;
  logic [ADDR_W-1:0]  r_rs2;
  logic [ADDR_W-1:0]  r_pipe_rd;
  logic               r_drain_done;
  logic               w_drain_done_nxt;
  logic               w_hazard;
  logic               w_hs;
  logic               w_cnt_zero;
  logic               w_credit_ok;
  logic               w_wb_dec;
  logic               w_wb_bad;

  assign w_cnt_zero  = (r_cnt == {CNT_W{1'b0}});
  assign w_credit_ok = (r_cnt < CNT_W'(MAX_INFLIGHT));
  // Only registered state gates acceptance; a same-cycle writeback frees nothing until next cycle.
  assign cmd_rdy     = (r_state != S_DRAIN) && !drain_req && w_credit_ok && !w_hazard;
  assign w_hs        = cmd_vld && cmd_rdy;
  assign w_wb_dec    = wb_vld && !w_cnt_zero;

`ifdef AT_SEQ_HAZARD_CHECK_EN
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_pending;

  assign w_hazard = r_pending[cmd_rs1] | r_pending[cmd_rs2] | r_pending[cmd_rd];
  assign w_wb_bad = wb_vld && (w_cnt_zero || !r_pending[wb_rd]);

  // One pending bit per destination; set and clear never hit the same address in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= {DEPTH{1'b0}};
    end else begin
      if (wb_vld) begin
        r_pending[wb_rd] <= 1'b0;
      end
      if (w_hs) begin
        r_pending[cmd_rd] <= 1'b1;
      end
    end
  end
`else
  assign w_hazard = 1'b0;
  assign w_wb_bad = wb_vld && w_cnt_zero;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_hs && !w_wb_dec) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (!w_hs && w_wb_dec) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_drain_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (drain_req) begin
          w_state_nxt = S_DRAIN;
        end else if (w_hs) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (drain_req) begin
          w_state_nxt = S_DRAIN;
        end else if (w_cnt_zero && !w_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_cnt_zero) begin
          w_state_nxt      = S_IDLE;
          w_drain_done_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rs1        <= {ADDR_W{1'b0}};
      r_rs2        <= {ADDR_W{1'b0}};
      r_pipe_rd    <= {ADDR_W{1'b0}};
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_busy       <= (w_cnt_nxt != {CNT_W{1'b0}});
      r_err        <= r_err | w_wb_bad;
      r_rd_en      <= w_hs;
      r_drain_done <= w_drain_done_nxt;
      // Addresses are held between launches; only the strobes are pulses.
      if (w_hs) begin
        r_rs1     <= cmd_rs1;
        r_rs2     <= cmd_rs2;
        r_pipe_rd <= cmd_rd;
      end
    end
  end

  assign mem_rd_en    = r_rd_en;
  assign mem_rs1      = r_rs1;
  assign mem_rs2      = r_rs2;
  assign pipe_vld     = r_rd_en;
  assign pipe_rd      = r_pipe_rd;
  assign mem_wr_en    = wb_vld;
  assign mem_wr_addr  = wb_rd;
  assign drain_done   = r_drain_done;
  assign busy         = r_busy;
  assign inflight_cnt = r_cnt;
  assign err          = r_err;

endmodule

// File: tb/tb_at_seq_ctrl.sv
// Self-checking bench for at_seq_ctrl: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_at_seq_ctrl;

  localparam int AW   = 4;
  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI + 1);
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rs1, mem_rs2;
  logic          pipe_vld;
  logic [AW-1:0] pipe_rd;
  logic          wb_vld;
  logic [AW-1:0] wb_rd;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic          drain_req;
  logic          drain_done;
  logic          busy;
  logic [CW-1:0] inflight_cnt;
  logic          err;

  int n_chk = 0;
  int n_err = 0;

  // reference model: in-flight tags, sticky error, controller mode
  logic [AW-1:0] q[$];
  logic          m_err;
  int            m_mode;

  typedef struct {
    logic          vld;
    logic [AW-1:0] rs1, rs2, rd;
    logic          wb;
    logic [AW-1:0] wbrd;
    logic          drq;
    logic          e_rdy;
    logic          e_rden;
    int            e_cnt;
    logic          e_err;
    logic          e_done;
  } vec_t;

  vec_t vt[30];

  at_seq_ctrl #(.ADDR_W(AW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .mem_rd_en(mem_rd_en), .mem_rs1(mem_rs1), .mem_rs2(mem_rs2),
    .pipe_vld(pipe_vld), .pipe_rd(pipe_rd),
    .wb_vld(wb_vld), .wb_rd(wb_rd),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy), .inflight_cnt(inflight_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit vld, input int rs1, input int rs2, input int rd,
                              input bit wb, input int wbrd, input bit drq,
                              input bit rdy, input bit rden, input int cnt,
                              input bit er, input bit done);
    vec_t v;
    v.vld = vld; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd);
    v.wb = wb; v.wbrd = AW'(wbrd); v.drq = drq;
    v.e_rdy = rdy; v.e_rden = rden; v.e_cnt = cnt; v.e_err = er; v.e_done = done;
    return v;
  endfunction

  function automatic int find_tag(input logic [AW-1:0] t);
    foreach (q[i]) if (q[i] == t) return i;
    return -1;
  endfunction

  task automatic drive(input logic vld, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic wb, input logic [AW-1:0] wbrd,
                       input logic drq);
    cmd_vld = vld; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    wb_vld = wb; wb_rd = wbrd; drain_req = drq;
  endtask

  // Holds reset for one edge, checks every output is cleared, resyncs the model.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rs1", mem_rs1, 0);
    check("rst_mem_rs2", mem_rs2, 0);
    check("rst_pipe_vld", pipe_vld, 0);
    check("rst_pipe_rd", pipe_rd, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", inflight_cnt, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    q.delete();
    m_err  = 1'b0;
    m_mode = M_IDLE;
  endtask

  // One clock cycle checked against the reference model.
  task automatic cycle(input logic vld, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic wb, input logic [AW-1:0] wbrd,
                       input logic drq);
    logic exp_rdy, hs, haz, exp_done;
    int   idx, n_before;
    drive(vld, rs1, rs2, rd, wb, wbrd, drq);
    #2;
    haz = 1'b0;
`ifdef AT_SEQ_HAZARD_CHECK_EN
    haz = (find_tag(rs1) >= 0) || (find_tag(rs2) >= 0) || (find_tag(rd) >= 0);
`endif
    n_before = q.size();
    exp_rdy  = (m_mode != M_DRAIN) && !drq && (n_before < MAXI) && !haz;
    check("cmd_rdy", cmd_rdy, exp_rdy);
    check("mem_wr_en", mem_wr_en, wb);
    check("mem_wr_addr", mem_wr_addr, wbrd);
    hs       = vld && exp_rdy;
    exp_done = (m_mode == M_DRAIN) && (n_before == 0);
    if (m_mode == M_DRAIN) m_mode = (n_before == 0) ? M_IDLE : M_DRAIN;
    else if (drq)          m_mode = M_DRAIN;
    else if (hs)           m_mode = M_RUN;
    else if (n_before == 0) m_mode = M_IDLE;
    if (wb) begin
      idx = find_tag(wbrd);
      if (n_before == 0) begin
        m_err = 1'b1;
      end else begin
`ifdef AT_SEQ_HAZARD_CHECK_EN
        if (idx < 0) m_err = 1'b1;
`endif
        q.delete((idx < 0) ? 0 : idx);
      end
    end
    if (hs) q.push_back(rd);
    @(posedge clk); #1;
    check("mem_rd_en", mem_rd_en, hs);
    check("pipe_vld", pipe_vld, hs);
    if (hs) begin
      check("mem_rs1", mem_rs1, rs1);
      check("mem_rs2", mem_rs2, rs2);
      check("pipe_rd", pipe_rd, rd);
    end
    check("inflight_cnt", inflight_cnt, q.size());
    check("busy", busy, q.size() != 0);
    check("err", err, m_err);
    check("drain_done", drain_done, exp_done);
  endtask

  initial begin
    // single command, full pipe, same-cycle credit, drain, underflow, empty drain
    vt[0]  = mk(1, 1, 2, 3,  0, 0, 0,  1, 1, 1, 0, 0);
    vt[1]  = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0);
    vt[2]  = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0);
    vt[3]  = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0);
    vt[4]  = mk(0, 0, 0, 0,  1, 3, 0,  1, 0, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0);
    vt[6]  = mk(1, 15, 15, 4, 0, 0, 0, 1, 1, 1, 0, 0);
    vt[7]  = mk(1, 15, 15, 5, 0, 0, 0, 1, 1, 2, 0, 0);
    vt[8]  = mk(1, 15, 15, 6, 0, 0, 0, 1, 1, 3, 0, 0);
    vt[9]  = mk(1, 15, 15, 7, 0, 0, 0, 1, 1, 4, 0, 0);
    vt[10] = mk(1, 15, 15, 8, 0, 0, 0, 0, 0, 4, 0, 0);
    vt[11] = mk(1, 15, 15, 8, 1, 4, 0, 0, 0, 3, 0, 0);
    vt[12] = mk(1, 15, 15, 8, 0, 0, 0, 1, 1, 4, 0, 0);
    vt[13] = mk(0, 0, 0, 0,  1, 5, 0,  0, 0, 3, 0, 0);
    vt[14] = mk(0, 0, 0, 0,  1, 6, 0,  1, 0, 2, 0, 0);
    vt[15] = mk(1, 15, 15, 9, 1, 7, 0, 1, 1, 2, 0, 0);
    vt[16] = mk(1, 15, 15, 10, 0, 0, 0, 1, 1, 3, 0, 0);
    vt[17] = mk(1, 15, 15, 11, 0, 0, 1, 0, 0, 3, 0, 0);
    vt[18] = mk(1, 15, 15, 11, 1, 8, 1, 0, 0, 2, 0, 0);
    vt[19] = mk(1, 15, 15, 11, 0, 0, 1, 0, 0, 2, 0, 0);
    vt[20] = mk(1, 15, 15, 11, 1, 9, 1, 0, 0, 1, 0, 0);
    vt[21] = mk(1, 15, 15, 11, 1, 10, 1, 0, 0, 0, 0, 0);
    vt[22] = mk(1, 15, 15, 11, 0, 0, 1, 0, 0, 0, 0, 1);
    vt[23] = mk(1, 15, 15, 11, 0, 0, 0, 1, 1, 1, 0, 0);
    vt[24] = mk(0, 0, 0, 0,  1, 11, 0, 1, 0, 0, 0, 0);
    vt[25] = mk(0, 0, 0, 0,  1, 12, 0, 1, 0, 0, 1, 0);
    vt[26] = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 0);
    vt[27] = mk(0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 1, 0);
    vt[28] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1);
    vt[29] = mk(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 0);

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 30; i++) begin
      drive(vt[i].vld, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wb, vt[i].wbrd, vt[i].drq);
      #2;
      check($sformatf("tbl%0d_cmd_rdy", i), cmd_rdy, vt[i].e_rdy);
      check($sformatf("tbl%0d_mem_wr_en", i), mem_wr_en, vt[i].wb);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_mem_rd_en", i), mem_rd_en, vt[i].e_rden);
      check($sformatf("tbl%0d_pipe_vld", i), pipe_vld, vt[i].e_rden);
      check($sformatf("tbl%0d_cnt", i), inflight_cnt, vt[i].e_cnt);
      check($sformatf("tbl%0d_busy", i), busy, vt[i].e_cnt != 0);
      check($sformatf("tbl%0d_err", i), err, vt[i].e_err);
      check($sformatf("tbl%0d_drain_done", i), drain_done, vt[i].e_done);
    end
    check("tbl0_addrs_unused", {28'd0, mem_rs1}, 32'd15);

`ifdef AT_SEQ_HAZARD_CHECK_EN
    do_reset();
    cycle(1'b1, 4'd0, 4'd1, 4'd5, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd5, 4'd1, 4'd7, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd5, 4'd1, 4'd7, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd5, 4'd1, 4'd7, 1'b1, 4'd5, 1'b0);
    cycle(1'b1, 4'd5, 4'd1, 4'd7, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd2, 4'd3, 4'd7, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd2, 4'd3, 4'd6, 1'b0, 4'd0, 1'b0);
`endif

    // reset with two commands in flight; their late results must flag err
    do_reset();
    cycle(1'b1, 4'd3, 4'd4, 4'd1, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd3, 4'd4, 4'd2, 1'b0, 4'd0, 1'b0);
    do_reset();
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd1, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);

    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic          v, w, d;
      logic [AW-1:0] a1, a2, ad, wt;
      v  = ($urandom_range(0, 99) < 65);
      a1 = AW'($urandom_range(0, 15));
      a2 = AW'($urandom_range(0, 15));
      ad = AW'($urandom_range(0, 15));
      d  = ($urandom_range(0, 99) < 6);
      w  = 1'b0;
      wt = AW'($urandom_range(0, 15));
      if (q.size() != 0) begin
        if ($urandom_range(0, 99) < 40) begin
          w  = 1'b1;
          wt = q[$urandom_range(0, q.size() - 1)];
        end
      end else if ($urandom_range(0, 199) == 0) begin
        w = 1'b1;
      end
      cycle(v, a1, a2, ad, w, wt, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
